// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-256 engine: opcodes, FSM states,
// round count, round constants and GF(2^8) arithmetic helpers.
package aes_pkg;

   localparam int unsigned NR = 14;

   localparam logic [6:0] OP_KEY = 7'd0;
   localparam logic [6:0] OP_ENC = 7'd1;
   localparam logic [6:0] OP_DEC = 7'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KEYEXP,
      ST_ENC,
      ST_DEC,
      ST_DONE
   } state_e;

   // Rcon[i] for AES-256 key expansion; entry 0 is unused.
   localparam logic [7:0] RCON [0:7] = '{8'h00, 8'h01, 8'h02, 8'h04,
                                         8'h08, 8'h10, 8'h20, 8'h40};

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES byte substitution: multiplicative inverse in GF(2^8)
// followed by the affine transform. With AES_DECRYPT_EN defined an inv_i
// select adds the inverse S-box (inverse affine, then field inverse).
module aes_sbox
   import aes_pkg::*;
(
`ifdef AES_DECRYPT_EN
   input  logic       inv_i,
`endif
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
      return 8'((a << n) | (a >> (8 - n)));
   endfunction

   // a^254 == a^-1 for a != 0, and 0 maps to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
      a2   = gmul(a, a);
      a3   = gmul(a2, a);
      a6   = gmul(a3, a3);
      a12  = gmul(a6, a6);
      a15  = gmul(a12, a3);
      a30  = gmul(a15, a15);
      a60  = gmul(a30, a30);
      a120 = gmul(a60, a60);
      a240 = gmul(a120, a120);
      a252 = gmul(a240, a12);
      return gmul(a252, a2);
   endfunction

   function automatic logic [7:0] fwd_affine(input logic [7:0] b);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

`ifdef AES_DECRYPT_EN
   function automatic logic [7:0] inv_affine(input logic [7:0] b);
      return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
   endfunction
`endif

   // Byte substitution (forward or inverse)
   always_comb begin
`ifdef AES_DECRYPT_EN
      if (inv_i) out_o = gf_inv(inv_affine(in_i));
      else       out_o = fwd_affine(gf_inv(in_i));
`else
      out_o = fwd_affine(gf_inv(in_i));
`endif
   end

endmodule

// File: rtl/aes_top.sv
// Iterative AES-256 coprocessor: key load (one round key per cycle),
// encrypt and decrypt (one round per cycle) behind a valid/ready command
// interface with a single request in flight.
// Optional feature macro: AES_DECRYPT_EN (inverse cipher for opcode 2).
module aes_top
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         input_valid,
   output logic         input_ready,
   input  logic [6:0]   opcode,
   input  logic [255:0] data_in,
   output logic         output_valid,
   input  logic         output_ready,
   output logic [127:0] data_out,
   output logic         busy
);

   localparam logic [3:0] LAST_RND = 4'(NR);

   state_e         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [127:0]   blk_q, blk_d;
   logic [127:0]   out_q, out_d;
   logic [127:0]   rk_q [0:NR];
   logic [127:0]   rk_d [0:NR];
   logic           key_loaded_q, key_loaded_d;
   logic           zero_q, zero_d;

   logic [127:0]   sub_bytes, rnd_key, rnd0_key, enc_res;
   logic [3:0]     rk_idx;

   logic [3:0]     ks_a, ks_b;
   logic [31:0]    ks_sbin, ks_sub, ks_t;
   logic [31:0]    ks_w0, ks_w1, ks_w2, ks_w3;
   logic [127:0]   ks_new;

`ifdef AES_DECRYPT_EN
   logic [127:0]   dec_res, rnd14_key;
   logic           dec_mode;
   assign dec_mode = (state_q == ST_DEC);
`endif

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned w = 0; w < 4; w++)
            r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c + w) % 4) + w) -: 8];
      return r;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] a);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = a;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int unsigned c = 0; c < 4; c++)
         r[127 - 32*c -: 32] = mix_col(s[127 - 32*c -: 32]);
      return r;
   endfunction

`ifdef AES_DECRYPT_EN
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned w = 0; w < 4; w++)
            r[127 - 8*(4*((c + w) % 4) + w) -: 8] = s[127 - 8*(4*c + w) -: 8];
      return r;
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = a;
      return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
              gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
              gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
              gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int unsigned c = 0; c < 4; c++)
         r[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
      return r;
   endfunction
`endif

   // State S-boxes: InvShiftRows and InvSubBytes commute, so both
   // directions substitute the raw state bytes before permuting.
   for (genvar g = 0; g < 16; g++) begin : g_state_sbox
      aes_sbox u_sbox (
`ifdef AES_DECRYPT_EN
         .inv_i (dec_mode),
`endif
         .in_i  (blk_q[127 - 8*g -: 8]),
         .out_o (sub_bytes[127 - 8*g -: 8])
      );
   end

   // Key-schedule S-boxes (SubWord on the last word of the previous round key)
   for (genvar g = 0; g < 4; g++) begin : g_key_sbox
      aes_sbox u_sbox (
`ifdef AES_DECRYPT_EN
         .inv_i (1'b0),
`endif
         .in_i  (ks_sbin[31 - 8*g -: 8]),
         .out_o (ks_sub[31 - 8*g -: 8])
      );
   end

   // Key-schedule operand select: round key r derives from r-2 and r-1
   always_comb begin
      ks_a    = (cnt_q >= 4'd2) ? cnt_q - 4'd2 : 4'd0;
      ks_b    = (cnt_q >= 4'd1) ? cnt_q - 4'd1 : 4'd0;
      ks_sbin = cnt_q[0] ? rk_q[ks_b][31:0]
                         : {rk_q[ks_b][23:0], rk_q[ks_b][31:24]};
   end

   // Next round key: even keys use RotWord+Rcon, odd keys plain SubWord
   always_comb begin
      ks_t   = ks_sub ^ (cnt_q[0] ? 32'h0 : {RCON[cnt_q[3:1]], 24'h0});
      ks_w0  = rk_q[ks_a][127:96] ^ ks_t;
      ks_w1  = rk_q[ks_a][95:64]  ^ ks_w0;
      ks_w2  = rk_q[ks_a][63:32]  ^ ks_w1;
      ks_w3  = rk_q[ks_a][31:0]   ^ ks_w2;
      ks_new = {ks_w0, ks_w1, ks_w2, ks_w3};
   end

   // Round datapath; without a loaded key the round keys read as zero
   always_comb begin
      rk_idx = cnt_q;
`ifdef AES_DECRYPT_EN
      if (dec_mode) rk_idx = LAST_RND - cnt_q;
      rnd14_key = key_loaded_q ? rk_q[NR] : '0;
`endif
      rnd_key  = key_loaded_q ? rk_q[rk_idx] : '0;
      rnd0_key = key_loaded_q ? rk_q[0] : '0;
      enc_res  = ((cnt_q == LAST_RND) ? shift_rows(sub_bytes)
                                      : mix_columns(shift_rows(sub_bytes))) ^ rnd_key;
`ifdef AES_DECRYPT_EN
      dec_res  = inv_shift_rows(sub_bytes) ^ rnd_key;
      if (cnt_q != LAST_RND) dec_res = inv_mix_columns(dec_res);
`endif
   end

   // Control FSM: next state and register updates
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      blk_d        = blk_q;
      out_d        = out_q;
      key_loaded_d = key_loaded_q;
      zero_d       = zero_q;
      for (int unsigned i = 0; i <= NR; i++) rk_d[i] = rk_q[i];

      case (state_q)
         ST_IDLE: begin
            if (input_valid) begin
               case (opcode)
                  OP_KEY: begin
                     rk_d[0]      = data_in[255:128];
                     rk_d[1]      = data_in[127:0];
                     key_loaded_d = 1'b1;
                     cnt_d        = 4'd2;
                     state_d      = ST_KEYEXP;
                  end
                  OP_ENC: begin
                     blk_d   = data_in[255:128] ^ rnd0_key;
                     zero_d  = 1'b0;
                     cnt_d   = 4'd1;
                     state_d = ST_ENC;
                  end
`ifdef AES_DECRYPT_EN
                  OP_DEC: begin
                     blk_d   = data_in[255:128] ^ rnd14_key;
                     cnt_d   = 4'd1;
                     state_d = ST_DEC;
                  end
`else
                  OP_DEC: begin
                     zero_d  = 1'b1;
                     cnt_d   = LAST_RND;
                     state_d = ST_ENC;
                  end
`endif
                  // Illegal opcodes ride one throw-away final encrypt round
                  // so DONE is reached one edge later with a zeroed result.
                  default: begin
                     zero_d  = 1'b1;
                     cnt_d   = LAST_RND;
                     state_d = ST_ENC;
                  end
               endcase
            end
         end
         ST_KEYEXP: begin
            rk_d[cnt_q] = ks_new;
            if (cnt_q == LAST_RND) begin
               out_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_ENC: begin
            if (cnt_q == LAST_RND) begin
               out_d   = zero_q ? '0 : enc_res;
               state_d = ST_DONE;
            end else begin
               blk_d = enc_res;
               cnt_d = cnt_q + 4'd1;
            end
         end
`ifdef AES_DECRYPT_EN
         ST_DEC: begin
            if (cnt_q == LAST_RND) begin
               out_d   = dec_res;
               state_d = ST_DONE;
            end else begin
               blk_d = dec_res;
               cnt_d = cnt_q + 4'd1;
            end
         end
`endif
         ST_DONE: begin
            if (output_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and storage registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         blk_q        <= '0;
         out_q        <= '0;
         key_loaded_q <= 1'b0;
         zero_q       <= 1'b0;
         for (int unsigned i = 0; i <= NR; i++) rk_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         blk_q        <= blk_d;
         out_q        <= out_d;
         key_loaded_q <= key_loaded_d;
         zero_q       <= zero_d;
         for (int unsigned i = 0; i <= NR; i++) rk_q[i] <= rk_d[i];
      end
   end

   assign input_ready  = (state_q == ST_IDLE);
   assign output_valid = (state_q == ST_DONE);
   assign busy         = (state_q != ST_IDLE);
   assign data_out     = out_q;

endmodule

// File: tb/tb_aes_top.sv
// Self-checking bench for aes_top: FIPS-197 C.3 vectors, handshake/latency
// behaviour, illegal opcodes, mid-operation reset, and randomized traffic
// compared against a byte-array AES-256 model.
module tb_aes_top;
   import aes_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         input_valid;
   logic         input_ready;
   logic [6:0]   opcode;
   logic [255:0] data_in;
   logic         output_valid;
   logic         output_ready;
   logic [127:0] data_out;
   logic         busy;

   always #5 clk = ~clk;

   aes_top dut (
      .clk          (clk),
      .rst          (rst),
      .input_valid  (input_valid),
      .input_ready  (input_ready),
      .opcode       (opcode),
      .data_in      (data_in),
      .output_valid (output_valid),
      .output_ready (output_ready),
      .data_out     (data_out),
      .busy         (busy)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // ---------------- reference model ----------------
   logic [7:0]   sbox_t  [256];
   logic [7:0]   isbox_t [256];
   logic [127:0] m_rk    [15];

   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 0; x = a; y = b;
      while (y != 0) begin
         if (y[0]) p = p ^ x;
         x = (x << 1) ^ ((x & 8'h80) != 0 ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] m_affine(input logic [7:0] x);
      logic [7:0] c, y;
      c = 8'h63;
      for (int i = 0; i < 8; i++)
         y[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8] ^ c[i];
      return y;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 0;
         if (a != 0)
            for (int b = 1; b < 256; b++)
               if (m_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sbox_t[a] = m_affine(inv);
         isbox_t[sbox_t[a]] = 8'(a);
      end
   endtask

   function automatic logic [31:0] m_subword(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   task automatic m_set_key(input logic [255:0] k);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            t = m_subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = m_mul(rc, 8'h02);
         end else if (i % 8 == 4) begin
            t = m_subword(t);
         end
         w[i] = w[i-8] ^ t;
      end
      for (int r = 0; r < 15; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic m_clear();
      for (int r = 0; r < 15; r++) m_rk[r] = '0;
   endtask

   function automatic logic [127:0] m_encrypt(input logic [127:0] din);
      logic [7:0] st [16];
      logic [7:0] t  [16];
      logic [7:0] a  [4];
      logic [127:0] o;
      for (int k = 0; k < 16; k++) st[k] = din[127-8*k -: 8] ^ m_rk[0][127-8*k -: 8];
      for (int rnd = 1; rnd <= 14; rnd++) begin
         for (int k = 0; k < 16; k++) t[k] = sbox_t[st[k]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) st[r + 4*c] = t[r + 4*((c + r) % 4)];
         if (rnd < 14)
            for (int c = 0; c < 4; c++) begin
               for (int r = 0; r < 4; r++) a[r] = st[4*c + r];
               for (int r = 0; r < 4; r++)
                  st[4*c + r] = m_mul(8'h02, a[r]) ^ m_mul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
            end
         for (int k = 0; k < 16; k++) st[k] = st[k] ^ m_rk[rnd][127-8*k -: 8];
      end
      for (int k = 0; k < 16; k++) o[127-8*k -: 8] = st[k];
      return o;
   endfunction

   function automatic logic [127:0] m_decrypt(input logic [127:0] din);
      logic [7:0] st [16];
      logic [7:0] t  [16];
      logic [7:0] a  [4];
      logic [127:0] o;
      for (int k = 0; k < 16; k++) st[k] = din[127-8*k -: 8] ^ m_rk[14][127-8*k -: 8];
      for (int rnd = 13; rnd >= 0; rnd--) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r + 4*((c + r) % 4)] = st[r + 4*c];
         for (int k = 0; k < 16; k++) st[k] = isbox_t[t[k]] ^ m_rk[rnd][127-8*k -: 8];
         if (rnd > 0)
            for (int c = 0; c < 4; c++) begin
               for (int r = 0; r < 4; r++) a[r] = st[4*c + r];
               for (int r = 0; r < 4; r++)
                  st[4*c + r] = m_mul(8'h0e, a[r]) ^ m_mul(8'h0b, a[(r+1)%4]) ^
                                m_mul(8'h0d, a[(r+2)%4]) ^ m_mul(8'h09, a[(r+3)%4]);
            end
      end
      for (int k = 0; k < 16; k++) o[127-8*k -: 8] = st[k];
      return o;
   endfunction

   // ---------------- stimulus helpers ----------------
   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Issue one command from a negedge and wait (bounded) for output_valid.
   // lat counts rising edges after the acceptance edge.
   task automatic run_cmd(input logic [6:0] op, input logic [255:0] din,
                          output logic [127:0] res, output int unsigned lat,
                          output logic busy_ok);
      int unsigned guard;
      guard = 0;
      while (!input_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      opcode = op; data_in = din; input_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      input_valid = 1'b0;
      opcode = 7'($urandom);
      data_in = {rand128(), rand128()};
      lat = 0;
      busy_ok = 1'b1;
      while (!output_valid && lat < 40) begin
         if (!busy || input_ready) busy_ok = 1'b0;
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      res = data_out;
   endtask

   task automatic ack();
      output_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      output_ready = 1'b0;
      check("ready_after_ack", input_ready, 1'b1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [255:0] fips_key;
      logic [127:0] fips_pt, fips_ct, pt, ct, res, exp_d, hold_val;
      int unsigned  lat, exp_lat;
      logic         bok, hold_ok;

      fips_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      fips_pt  = 128'h00112233445566778899aabbccddeeff;
      fips_ct  = 128'h8ea2b7ca516745bfeafc49904b496089;

      rst = 1'b1; input_valid = 1'b0; output_ready = 1'b0; opcode = '0; data_in = '0;
      build_sbox();
      m_clear();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_input_ready",  input_ready,  1'b1);
      check("rst_output_valid", output_valid, 1'b0);
      check("rst_busy",         busy,         1'b0);
      check("rst_data_out",     data_out,     '0);

      // Encrypt with no key loaded: all-zero round keys
      pt = rand128();
      run_cmd(OP_ENC, {pt, rand128()}, res, lat, bok);
      check("enc_nokey_lat",  lat, 14);
      check("enc_nokey_data", res, m_encrypt(pt));
      ack();

      // FIPS-197 C.3 key load
      run_cmd(OP_KEY, fips_key, res, lat, bok);
      check("key_lat",  lat, 13);
      check("key_data", res, '0);
      check("key_busy", bok, 1'b1);
      ack();
      m_set_key(fips_key);

      run_cmd(OP_ENC, {fips_pt, rand128()}, res, lat, bok);
      check("fips_enc_lat",  lat, 14);
      check("fips_enc_data", res, fips_ct);
      check("fips_enc_busy", bok, 1'b1);
      ack();

`ifdef AES_DECRYPT_EN
      exp_lat = 14; exp_d = fips_pt;
`else
      exp_lat = 1;  exp_d = '0;
`endif
      run_cmd(OP_DEC, {fips_ct, rand128()}, res, lat, bok);
      check("fips_dec_lat",  lat, exp_lat);
      check("fips_dec_data", res, exp_d);
      ack();

      // Back-pressure: result held, commands ignored while not ready
      pt = rand128();
      run_cmd(OP_ENC, {pt, rand128()}, res, lat, bok);
      check("hold_first", res, m_encrypt(pt));
      hold_val = res;
      hold_ok = 1'b1;
      opcode = OP_KEY; data_in = {rand128(), rand128()}; input_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (!output_valid || input_ready || data_out !== hold_val) hold_ok = 1'b0;
      end
      input_valid = 1'b0;
      check("hold_stable", hold_ok, 1'b1);
      ack();
      pt = rand128();
      run_cmd(OP_ENC, {pt, rand128()}, res, lat, bok);
      check("after_hold_key_kept", res, m_encrypt(pt));
      ack();

      // Illegal opcode
      run_cmd(7'd5, {rand128(), rand128()}, res, lat, bok);
      check("op5_lat",  lat, 1);
      check("op5_data", res, '0);
      ack();
      run_cmd(7'h7f, {rand128(), rand128()}, res, lat, bok);
      check("op7f_lat",  lat, 1);
      check("op7f_data", res, '0);
      ack();

      // Randomized keys and blocks
      for (int it = 0; it < 3; it++) begin
         fips_key = {rand128(), rand128()};
         run_cmd(OP_KEY, fips_key, res, lat, bok);
         check("rnd_key_lat", lat, 13);
         ack();
         m_set_key(fips_key);
         pt = rand128();
         run_cmd(OP_ENC, {pt, rand128()}, ct, lat, bok);
         check("rnd_enc", ct, m_encrypt(pt));
         ack();
`ifdef AES_DECRYPT_EN
         exp_d = pt;
`else
         exp_d = '0;
`endif
         run_cmd(OP_DEC, {ct, rand128()}, res, lat, bok);
         check("rnd_dec_roundtrip", res, exp_d);
         ack();
         pt = rand128();
`ifdef AES_DECRYPT_EN
         exp_d = m_decrypt(pt);
`else
         exp_d = '0;
`endif
         run_cmd(OP_DEC, {pt, rand128()}, res, lat, bok);
         check("rnd_dec", res, exp_d);
         ack();
      end

      // Reset in the middle of an encrypt
      opcode = OP_ENC; data_in = {fips_pt, 128'h0}; input_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      input_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_busy", busy, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_valid",    output_valid, 1'b0);
      check("mid_rst_busy",     busy,         1'b0);
      check("mid_rst_ready",    input_ready,  1'b1);
      check("mid_rst_data_out", data_out,     '0);
      m_clear();
      pt = rand128();
      run_cmd(OP_ENC, {pt, rand128()}, res, lat, bok);
      check("post_rst_enc_lat",  lat, 14);
      check("post_rst_enc_data", res, m_encrypt(pt));
      ack();
      pt = rand128();
`ifdef AES_DECRYPT_EN
      exp_d = m_decrypt(pt);
`else
      exp_d = '0;
`endif
      run_cmd(OP_DEC, {pt, rand128()}, res, lat, bok);
      check("post_rst_dec_data", res, exp_d);
      ack();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/aes_top.md
# aes_top

Iterative AES-256 engine with an opcode-driven valid/ready command interface: load a 256-bit key, encrypt a 128-bit block, or decrypt a 128-bit block. It sits between a host command stream and the datapath as a single-request-in-flight coprocessor. The key schedule is computed once per key load and stored for all later encrypt/decrypt operations.

## Interface
- No parameters; AES-256 only (Nk=8, Nr=14).
- clk  in  1  sole clock, rising-edge
- rst  in  1  reset, synchronous, active-high
- input_valid  in  1  command present on opcode/data_in
- input_ready  out  1  engine can accept a command
- opcode  in  7  0 = load key, 1 = encrypt, 2 = decrypt, others illegal
- data_in  in  256  key (opcode 0); block in [255:128], [127:0] ignored (opcodes 1/2)
- output_valid  out  1  result present on data_out
- output_ready  in  1  consumer accepts result
- data_out  out  128  ciphertext/plaintext; 0 for key load and illegal opcodes
- busy  out  1  engine not idle

## Operation
- Byte order big-endian: key byte 0 = data_in[255:248]; block byte 0 = data_in[255:248]; data_out byte 0 = data_out[127:120]; column-major AES state.
- States: IDLE, KEYEXP, ENC, DEC, DONE.
- IDLE: input_ready=1; accept on input_valid&&input_ready; opcode/data captured at that edge.
- Opcode 0: store 15 round keys (15x128-bit register file) via standard FIPS-197 expansion, one round key per cycle -> DONE, data_out=0; sets key_loaded.
- Opcode 1: FIPS-197 cipher, one round per cycle (SubBytes, ShiftRows, MixColumns except last round, AddRoundKey) -> DONE.
- Opcode 2: FIPS-197 inverse cipher using the same stored schedule in reverse (round keys 14..0), one round per cycle -> DONE.
- Illegal opcode: accepted, -> DONE next edge with data_out=0.
- Encrypt/decrypt with no key loaded since reset uses all-zero round-key registers (not the expansion of a zero key).
- DONE: output_valid=1, data_out stable; on output_ready -> IDLE.
- busy = (state != IDLE).
- Reset (any time, incl. mid-operation): state IDLE, input_ready=1, output_valid=0, busy=0, data_out=0, round keys and key_loaded cleared; operation in flight discarded.

## Timing
- Acceptance edge E0.
- Key load: rk0/rk1 written at E0, rk2..rk14 at E1..E13, output_valid high after E13 (13 cycles).
- Encrypt/decrypt: initial AddRoundKey at E0, rounds at E1..E14, output_valid high after E14 (14 cycles).
- Illegal opcode: output_valid high after E1.
- Output handshake at edge with output_valid&&output_ready; input_ready high the following cycle (no same-cycle accept in DONE). Minimum back-to-back spacing: latency + 1 cycle.
- input_valid ignored while input_ready=0; output_ready ignored while output_valid=0.
- output_valid and data_out hold indefinitely under output_ready=0.

## Configuration
- AES_DECRYPT_EN defined: opcode 2 performs decryption as above; inverse S-box and InvMixColumns present.
- Undefined: no inverse datapath; opcode 2 treated as an illegal opcode (data_out=0 after 1 cycle).

## Structure
- Package aes_pkg: opcode constants (OP_KEY=0, OP_ENC=1, OP_DEC=2), state enum, Nr=14, Rcon table, GF(2^8) xtime/multiply functions.
- Sub-module aes_sbox: combinational byte S-box, inverse S-box under AES_DECRYPT_EN; instantiated 16x for state plus 4x for key expansion.

## Test plan
- FIPS-197 C.3: key 000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, encrypt 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
- Same key, decrypt 8ea2b7ca516745bfeafc49904b496089 -> 00112233445566778899aabbccddeeff (with AES_DECRYPT_EN).
- Key load -> output_valid after 13 cycles, data_out=0, busy high throughout, input_ready low until handshake.
- Hold output_ready=0 for 10 cycles after output_valid -> data_out stable, no new command accepted; release -> input_ready next cycle.
- Opcode 5 -> data_out=0 after 1 cycle; without AES_DECRYPT_EN opcode 2 behaves identically.
- Assert rst mid-encrypt -> next cycle output_valid=0, busy=0, input_ready=1; encrypt without reload uses zero round keys.
